// File: rtl/cram_psram_ctrl.sv
// rtl/cram_psram_ctrl.sv - cart-RAM word port to async muxed-address/data PSRAM bridge
//
// Purpose: keeps the word at the current {bank_sel, addr} readable on data_out
// through background reads, and buffers one write which has priority over reads.
// Optional feature macro: CRAM_WRITE_FORWARD_EN (merge captured write lanes into
// data_out when the write hits the tagged address).
//
// Ports:
//   clk_sys, reset          system clock, synchronous active-high reset
//   bank_sel, addr          chip select (0 = ce0, 1 = ce1) and 16-bit word address
//   write_en, write_*_byte  level write request and byte-lane enables
//   data_in                 write data
//   read_en                 allow background reads
//   data_out, read_avail    last word read (pulse when it updates)
//   busy                    write buffer occupied
//   cram_*                  external PSRAM pins (async mode; cram_wait unused)
module cram_psram_ctrl #(
  parameter int ADDR_CYCLES    = 2,
  parameter int ACCESS_CYCLES  = 5,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        bank_sel,
  input  logic [15:0] addr,
  input  logic        write_en,
  input  logic        write_high_byte,
  input  logic        write_low_byte,
  input  logic        read_en,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        read_avail,
  output logic        busy,
  output logic [5:0]  cram_a,
  inout  wire  [15:0] cram_dq,
  input  logic        cram_wait,
  output logic        cram_clk,
  output logic        cram_adv_n,
  output logic        cram_cre,
  output logic        cram_ce0_n,
  output logic        cram_ce1_n,
  output logic        cram_oe_n,
  output logic        cram_we_n,
  output logic        cram_ub_n,
  output logic        cram_lb_n
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LATCH, S_RD_WAIT, S_WR_WAIT, S_RECOVER} state_t;

  // Write tuple layout: {bank[34], addr[33:18], hi[17], lo[16], data[15:0]}
  localparam int TW = 35;
  localparam logic [3:0] ADDR_LAST    = 4'(ADDR_CYCLES - 1);
  localparam logic [3:0] ACCESS_LAST  = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] RECOVER_LAST = 4'(RECOVER_CYCLES - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          prev_we_q, prev_we_d;
  logic [TW-1:0] last_tuple_q, last_tuple_d;
  logic          buf_valid_q, buf_valid_d, buf_fwd_q, buf_fwd_d;
  logic [TW-1:0] buf_tuple_q, buf_tuple_d;
  logic          hold_valid_q, hold_valid_d, hold_fwd_q, hold_fwd_d;
  logic [TW-1:0] hold_tuple_q, hold_tuple_d;
  logic          acc_bank_q, acc_bank_d, acc_wr_q, acc_wr_d;
  logic [15:0]   acc_addr_q, acc_addr_d;
  logic          tag_valid_q, tag_valid_d;
  logic [16:0]   tag_q, tag_d;
  logic [15:0]   data_out_q, data_out_d;
  logic          read_avail_q, read_avail_d;
  logic          ce0_n_q, ce0_n_d, ce1_n_q, ce1_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic          adv_n_q, adv_n_d, ub_n_q, ub_n_d, lb_n_q, lb_n_d;
  logic          dq_oe_q, dq_oe_d;
  logic [15:0]   dq_out_q, dq_out_d;

  logic [TW-1:0] tuple_in;
  logic          capture, fwd_hit, wr_in_flight, wr_done, rd_done, ce_on;
  logic          unused_wait;

  assign unused_wait  = cram_wait;
  assign tuple_in     = {bank_sel, addr, write_high_byte, write_low_byte, data_in};
  assign wr_done      = (state_q == S_WR_WAIT) && (cnt_q == 4'd0);
  assign rd_done      = (state_q == S_RD_WAIT) && (cnt_q == 4'd0);
  // A buffered write counts as started from the IDLE cycle that launches it.
  assign wr_in_flight = (state_q == S_IDLE) ? buf_valid_q : (acc_wr_q && state_q != S_RECOVER);
  assign capture      = write_en && (write_high_byte || write_low_byte) &&
                        (!prev_we_q || tuple_in != last_tuple_q);
`ifdef CRAM_WRITE_FORWARD_EN
  // Not forwarded while a read retags this cycle; such a write invalidates on completion.
  assign fwd_hit = capture && tag_valid_q && !rd_done && (tag_q == {bank_sel, addr});
`else
  assign fwd_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;       cnt_d        = cnt_q;
    prev_we_d    = write_en;      last_tuple_d = last_tuple_q;
    buf_valid_d  = buf_valid_q;   buf_tuple_d  = buf_tuple_q;   buf_fwd_d  = buf_fwd_q;
    hold_valid_d = hold_valid_q;  hold_tuple_d = hold_tuple_q;  hold_fwd_d = hold_fwd_q;
    acc_bank_d   = acc_bank_q;    acc_addr_d   = acc_addr_q;    acc_wr_d   = acc_wr_q;
    tag_valid_d  = tag_valid_q;   tag_d        = tag_q;
    data_out_d   = data_out_q;    read_avail_d = 1'b0;
    ce_on        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (buf_valid_q) begin
          state_d    = S_ADDR;  cnt_d = ADDR_LAST;  acc_wr_d = 1'b1;
          acc_bank_d = buf_tuple_q[34];
          acc_addr_d = buf_tuple_q[33:18];
        end else if (read_en && (!tag_valid_q || tag_q != {bank_sel, addr})) begin
          state_d    = S_ADDR;  cnt_d = ADDR_LAST;  acc_wr_d = 1'b0;
          acc_bank_d = bank_sel;
          acc_addr_d = addr;
        end
      end
      S_ADDR: begin
        if (cnt_q == 4'd0) state_d = S_LATCH;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_LATCH: begin
        state_d = acc_wr_q ? S_WR_WAIT : S_RD_WAIT;
        cnt_d   = ACCESS_LAST;
      end
      S_RD_WAIT: begin
        if (rd_done) begin
          data_out_d   = cram_dq;
          read_avail_d = 1'b1;
          tag_d        = {acc_bank_q, acc_addr_q};
          tag_valid_d  = 1'b1;
          state_d      = S_RECOVER;
          cnt_d        = RECOVER_LAST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR_WAIT: begin
        if (wr_done) begin
          // A forwarded write already left data_out current, so the tag may stay.
          if (tag_valid_q && tag_q == {acc_bank_q, acc_addr_q} && !buf_fwd_q)
            tag_valid_d = 1'b0;
          state_d = S_RECOVER;
          cnt_d   = RECOVER_LAST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RECOVER: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Completed write frees the buffer; a write held during the access moves in.
    if (wr_done) begin
      buf_valid_d  = hold_valid_q;
      buf_tuple_d  = hold_tuple_q;
      buf_fwd_d    = hold_fwd_q;
      hold_valid_d = 1'b0;
    end
    // Newest capture always wins over any not-yet-started tuple.
    if (capture) begin
      last_tuple_d = tuple_in;
      if (wr_in_flight && !wr_done) begin
        hold_valid_d = 1'b1;  hold_tuple_d = tuple_in;  hold_fwd_d = fwd_hit;
      end else begin
        buf_valid_d  = 1'b1;  buf_tuple_d  = tuple_in;  buf_fwd_d  = fwd_hit;
      end
    end
    if (fwd_hit) begin
      if (write_high_byte) data_out_d[15:8] = data_in[15:8];
      if (write_low_byte)  data_out_d[7:0]  = data_in[7:0];
      read_avail_d = 1'b1;
    end

    // Pins are registered from the next state so they line up with state_q.
    ce_on    = (state_d == S_ADDR) || (state_d == S_LATCH) ||
               (state_d == S_RD_WAIT) || (state_d == S_WR_WAIT);
    ce0_n_d  = !(ce_on && !acc_bank_d);
    ce1_n_d  = !(ce_on && acc_bank_d);
    adv_n_d  = (state_d != S_ADDR);
    oe_n_d   = (state_d != S_RD_WAIT);
    we_n_d   = (state_d != S_WR_WAIT);
    ub_n_d   = !((state_d == S_RD_WAIT) || (state_d == S_WR_WAIT && buf_tuple_q[17]));
    lb_n_d   = !((state_d == S_RD_WAIT) || (state_d == S_WR_WAIT && buf_tuple_q[16]));
    dq_oe_d  = (state_d == S_ADDR) ||
               (acc_wr_d && (state_d == S_LATCH || state_d == S_WR_WAIT));
    dq_out_d = (state_d == S_ADDR) ? acc_addr_d : buf_tuple_q[15:0];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_IDLE;  cnt_q        <= '0;
      prev_we_q    <= 1'b0;    last_tuple_q <= '0;
      buf_valid_q  <= 1'b0;    buf_tuple_q  <= '0;  buf_fwd_q  <= 1'b0;
      hold_valid_q <= 1'b0;    hold_tuple_q <= '0;  hold_fwd_q <= 1'b0;
      acc_bank_q   <= 1'b0;    acc_addr_q   <= '0;  acc_wr_q   <= 1'b0;
      tag_valid_q  <= 1'b0;    tag_q        <= '0;
      data_out_q   <= '0;      read_avail_q <= 1'b0;
      ce0_n_q      <= 1'b1;    ce1_n_q      <= 1'b1;  oe_n_q <= 1'b1;  we_n_q <= 1'b1;
      adv_n_q      <= 1'b1;    ub_n_q       <= 1'b1;  lb_n_q <= 1'b1;
      dq_oe_q      <= 1'b0;    dq_out_q     <= '0;
    end else begin
      state_q      <= state_d;       cnt_q        <= cnt_d;
      prev_we_q    <= prev_we_d;     last_tuple_q <= last_tuple_d;
      buf_valid_q  <= buf_valid_d;   buf_tuple_q  <= buf_tuple_d;   buf_fwd_q  <= buf_fwd_d;
      hold_valid_q <= hold_valid_d;  hold_tuple_q <= hold_tuple_d;  hold_fwd_q <= hold_fwd_d;
      acc_bank_q   <= acc_bank_d;    acc_addr_q   <= acc_addr_d;    acc_wr_q   <= acc_wr_d;
      tag_valid_q  <= tag_valid_d;   tag_q        <= tag_d;
      data_out_q   <= data_out_d;    read_avail_q <= read_avail_d;
      ce0_n_q      <= ce0_n_d;       ce1_n_q      <= ce1_n_d;  oe_n_q <= oe_n_d;  we_n_q <= we_n_d;
      adv_n_q      <= adv_n_d;       ub_n_q       <= ub_n_d;   lb_n_q <= lb_n_d;
      dq_oe_q      <= dq_oe_d;       dq_out_q     <= dq_out_d;
    end
  end

  assign cram_dq    = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign cram_a     = 6'd0;
  assign cram_clk   = 1'b0;
  assign cram_cre   = 1'b0;
  assign cram_ce0_n = ce0_n_q;
  assign cram_ce1_n = ce1_n_q;
  assign cram_oe_n  = oe_n_q;
  assign cram_we_n  = we_n_q;
  assign cram_adv_n = adv_n_q;
  assign cram_ub_n  = ub_n_q;
  assign cram_lb_n  = lb_n_q;
  assign data_out   = data_out_q;
  assign read_avail = read_avail_q;
  assign busy       = buf_valid_q;

endmodule
